// File: rtl/pio_pkg.sv
// Shared constants for the switch/key input PIO: s1 register offsets and edge-type encodings.
// Latency: none (constants only).
// Backpressure: none (constants only).
package pio_pkg;

  // s1 word offsets
  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  // Which transitions of the filtered input set an edge_capture bit
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Avalon data bus width
  localparam int PIO_BUS_W = 32;

  // Warm-up counter saturates here; edge capture is enabled only once it is reached
  localparam logic [1:0] PIO_WARM_DONE = 2'd3;

endpackage : pio_pkg

// File: rtl/pio_in_debounce.sv
// One-bit debounce filter: filtered output follows the input only after it has differed for DEBOUNCE_CYCLES cycles.
// Latency: DEBOUNCE_CYCLES cycles from a stable input change to the filtered output.
// Backpressure: none; samples every cycle.
module pio_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_i,
  output logic filt_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Count consecutive cycles of disagreement; any agreement restarts the count
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sample_i != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sample_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and filtered value registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule : pio_in_debounce

// File: rtl/experiment1b_sw_pio_in.sv
// Avalon-MM s1 input PIO for switches/keys with per-bit edge capture and maskable level irq.
// Latency: in_port -> data 2 edges, -> edge_capture/irq 3 edges (+DEBOUNCE_CYCLES with PIO_IN_DEBOUNCE_EN); reads are zero-wait.
// Backpressure: none; every s1 access completes in the cycle it is presented.
// Optional feature: define PIO_IN_DEBOUNCE_EN to insert a per-bit debounce filter after the synchronizer.
module experiment1b_sw_pio_in
  import pio_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int EDGE_TYPE       = EDGE_RISE,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_evt, edge_clr;
  logic [1:0]       warm_q, warm_d;
  logic             warm_done;
  logic             wr_en, wr_mask, wr_edge;

  // Bus decode
  assign wr_en   = chipselect & ~write_n;
  assign wr_mask = wr_en & (address == PIO_ADDR_MASK);
  assign wr_edge = wr_en & (address == PIO_ADDR_EDGE);

  // Two-flop synchronizer for the asynchronous switch inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .sample_i(sync2_q[i]),
      .filt_o  (filt[i])
    );
  end
`else
  // Filter bypassed; the debounce length only matters when the filter is built
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign filt = sync2_q;
`endif

  // Data above WIDTH is never stored
  if (WIDTH < PIO_BUS_W) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[PIO_BUS_W-1:WIDTH];
  end

  // Pick the transitions that count as an event for this instance
  always_comb begin
    edge_evt = filt & ~prev_q;
    case (EDGE_TYPE)
      EDGE_FALL: edge_evt = ~filt & prev_q;
      EDGE_ANY:  edge_evt = filt ^ prev_q;
      default:   edge_evt = filt & ~prev_q;
    endcase
  end

  // Warm-up keeps inputs already asserted at reset release from looking like edges
  always_comb begin
    warm_done = (warm_q == PIO_WARM_DONE);
    warm_d    = warm_done ? warm_q : warm_q + 2'd1;
  end

  // Next state for mask and edge_capture; a new edge beats a same-cycle clear
  always_comb begin
    mask_d   = wr_mask ? writedata[WIDTH-1:0] : mask_q;
    edge_clr = wr_edge ? writedata[WIDTH-1:0] : '0;
    edge_d   = (edge_q & ~edge_clr) | (warm_done ? edge_evt : '0);
  end

  // Edge-detect history, warm-up counter and software-visible registers
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      warm_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      prev_q <= filt;
      warm_q <= warm_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

  // Zero-wait read mux; reads have no side effects
  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA: readdata[WIDTH-1:0] = filt;
      PIO_ADDR_RSVD: readdata            = '0;
      PIO_ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
      PIO_ADDR_EDGE: readdata[WIDTH-1:0] = edge_q;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule : experiment1b_sw_pio_in

// File: tb/tb_experiment1b_sw_pio_in.sv
// Directed bench for the input PIO: a rising-edge instance and an any-edge instance share one s1 bus.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
`timescale 1ns/1ps
module tb_experiment1b_sw_pio_in;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;
  logic [31:0]  rd_r, rd_a;
  logic         irq_r, irq_a;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  experiment1b_sw_pio_in #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r)
  );

  experiment1b_sw_pio_in #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic sel(input logic [1:0] a);
    address = a;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
`ifdef PIO_IN_DEBOUNCE_EN
    in_port = '0;
    tick(2);
    sel(2'd0); chk("db_rst_data", rd_r, 32'h0);
    reset = 1'b0;
    tick(4);
    wr(2'd2, 32'h1);
    // 10-cycle glitch must be filtered out
    in_port = 18'h1;
    tick(10);
    in_port = 18'h0;
    tick(25);
    sel(2'd0); chk("db_glitch_data", rd_r, 32'h0);
    sel(2'd3); chk("db_glitch_edge", rd_r, 32'h0);
    chk("db_glitch_irq", {31'd0, irq_r}, 32'h0);
    // held input: 2 sync edges + 16 stable cycles
    in_port = 18'h1;
    tick(17);
    sel(2'd0); chk("db_hold17_data", rd_r, 32'h0);
    tick(1);
    sel(2'd0); chk("db_hold18_data", rd_r, 32'h1);
    sel(2'd3); chk("db_hold18_edge", rd_r, 32'h0);
    tick(1);
    sel(2'd3); chk("db_hold19_edge", rd_r, 32'h1);
    chk("db_hold19_irq", {31'd0, irq_r}, 32'h1);
    // reset in the middle of a count
    in_port = 18'h3;
    tick(8);
    reset = 1'b1;
    tick(1);
    sel(2'd0); chk("db_mid_rst_data", rd_r, 32'h0);
    sel(2'd2); chk("db_mid_rst_mask", rd_r, 32'h0);
    sel(2'd3); chk("db_mid_rst_edge", rd_r, 32'h0);
    chk("db_mid_rst_irq", {31'd0, irq_r}, 32'h0);
    reset = 1'b0;
    tick(3);
    sel(2'd0); chk("db_refilter_data", rd_r, 32'h0);
`else
    // Reset with every switch already on
    in_port = 18'h3FFFF;
    tick(2);
    sel(2'd0); chk("rst_data", rd_r, 32'h0);
    chk("rst_irq", {31'd0, irq_r}, 32'h0);
    reset = 1'b0;
    tick(1);
    sel(2'd0); chk("rst_lat1_data", rd_r, 32'h0);
    tick(2);
    sel(2'd0); chk("rst_lat3_data", rd_r, 32'h3FFFF);
    sel(2'd3); chk("rst_lat3_edge", rd_r, 32'h0);
    chk("rst_lat3_irq", {31'd0, irq_r}, 32'h0);
    tick(2);
    sel(2'd3); chk("warm_edge_rise", rd_r, 32'h0);
    chk("warm_edge_any", rd_a, 32'h0);

    // Basic rising edge, irq and W1C
    in_port = 18'h0;
    tick(4);
    wr(2'd3, 32'hFFFF_FFFF);
    sel(2'd3); chk("t2_clr_rise", rd_r, 32'h0);
    chk("t2_clr_any", rd_a, 32'h0);
    wr(2'd2, 32'h1);
    sel(2'd2); chk("t2_mask", rd_r, 32'h1);
    in_port = 18'h1;
    tick(2);
    sel(2'd0); chk("t2_data", rd_r, 32'h1);
    sel(2'd3); chk("t2_edge_early", rd_r, 32'h0);
    tick(1);
    sel(2'd3); chk("t2_edge", rd_r, 32'h1);
    chk("t2_irq", {31'd0, irq_r}, 32'h1);
    wr(2'd3, 32'h1);
    sel(2'd3); chk("t2_w1c_edge", rd_r, 32'h0);
    chk("t2_w1c_irq", {31'd0, irq_r}, 32'h0);

    // Edge and clear on bit5 in the same cycle: set wins
    in_port = 18'h21;
    tick(2);
    wr(2'd3, 32'h20);
    sel(2'd3); chk("t3_collide", rd_r, 32'h20);
    wr(2'd3, 32'h20);
    sel(2'd3); chk("t3_clear", rd_r, 32'h0);

    // Masked capture, then unmask
    wr(2'd2, 32'h0);
    in_port = 18'h29;
    tick(3);
    sel(2'd3); chk("t4_edge", rd_r, 32'h8);
    chk("t4_irq_masked", {31'd0, irq_r}, 32'h0);
    wr(2'd2, 32'h8);
    chk("t4_irq_unmask", {31'd0, irq_r}, 32'h1);
    wr(2'd2, 32'h0);
    chk("t4_irq_remask", {31'd0, irq_r}, 32'h0);
    sel(2'd3); chk("t4_edge_kept", rd_r, 32'h8);
    wr(2'd3, 32'h8);

    // Any-edge instance sees both transitions of bit17
    wr(2'd3, 32'hFFFF_FFFF);
    sel(2'd3); chk("t5_clr_any", rd_a, 32'h0);
    wr(2'd2, 32'h20000);
    in_port = 18'h20029;
    tick(3);
    sel(2'd3); chk("t5_rise_any", rd_a, 32'h20000);
    chk("t5_rise_rise", rd_r, 32'h20000);
    chk("t5_rise_irq", {31'd0, irq_a}, 32'h1);
    wr(2'd3, 32'h20000);
    sel(2'd3); chk("t5_clr2_any", rd_a, 32'h0);
    in_port = 18'h00029;
    tick(3);
    sel(2'd3); chk("t5_fall_any", rd_a, 32'h20000);
    chk("t5_fall_rise", rd_r, 32'h0);
    chk("t5_fall_irq_any", {31'd0, irq_a}, 32'h1);
    chk("t5_fall_irq_rise", {31'd0, irq_r}, 32'h0);
    sel(2'd1); chk("t5_rsvd", rd_r, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h0000_FFFF);
    sel(2'd0); chk("t5_data_ro", rd_r, 32'h29);
    sel(2'd1); chk("t5_rsvd_wr", rd_a, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    sel(2'd2); chk("t5_mask_hi", rd_r, 32'h3FFFF);

    // Reset during an active write
    reset      = 1'b1;
    address    = 2'd2;
    writedata  = 32'h5;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    sel(2'd0); chk("mid_rst_data", rd_r, 32'h0);
    sel(2'd2); chk("mid_rst_mask", rd_a, 32'h0);
    sel(2'd3); chk("mid_rst_edge", rd_a, 32'h0);
    chk("mid_rst_irq_any", {31'd0, irq_a}, 32'h0);
    chk("mid_rst_irq_rise", {31'd0, irq_r}, 32'h0);
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset      = 1'b0;
    tick(2);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_experiment1b_sw_pio_in
